cubo_multi_caida: RTL and testbench
===================================

// Module: cubo_multi_caida
// PURPOSE
//  Parametrised manager for N_CUBOS independent falling cubes on a 640x480 VGA raster.
//  Accepts spawn requests (x position, speed) over a valid/ready handshake and allocates them to free slots.
//  Advances every active cube once per frame and retires cubes that leave the screen.
//  Produces a registered per-pixel paint flag plus the index of the painted cube for the colour mux.
// PARAMETERS
//  N_CUBOS    4    number of cube slots (>=2)
//  CUBO_SIZE  64   cube side in pixels
//  MAX_X      640  visible width
//  MAX_Y      480  visible height; a cube retires when its bottom edge y >= MAX_Y
//  TICK_Y     481  pixel_y line that generates the frame tick (pixel_x==0)
//  V_W        3    speed field width, pixels per frame
// PORTS
//  clk          in   1          system clock
//  reset_n      in   1          asynchronous reset, active low
//  pixel_x      in   10         raster column
//  pixel_y      in   10         raster row
//  spawn_valid  in   1          spawn request
//  spawn_ready  out  1          at least one slot IDLE
//  spawn_x      in   10         left edge of the new cube (0..MAX_X-CUBO_SIZE)
//  spawn_vel    in   V_W        fall speed; 0 is legal (cube stays put)
//  active_mask  out  N_CUBOS    bit i = slot i FALLING
//  done_mask    out  N_CUBOS    bit i pulses for 1 cycle when slot i retires
//  pintar_cubo  out  1          current pixel lies inside an active cube (1-cycle latency)
//  cubo_idx     out  clog2(N)   lowest-index cube covering the pixel; 0 when pintar_cubo=0
// BEHAVIOUR
//  - Reset (async, reset_n=0): all slots IDLE, x=0, y=0; every output 0 except spawn_ready=1 once reset releases.
//  - Frame tick: 1-cycle pulse on the rising edge of (pixel_y==TICK_Y && pixel_x==0), from a registered previous value.
//    A condition held for several cycles gives exactly 1 tick.
//  - Spawn: accepted when spawn_valid && spawn_ready in cycle k; goes to the lowest-index IDLE slot.
//    That slot is FALLING at k+1 with y_bot=0, x=spawn_x and vel latched. At most 1 spawn per cycle.
//  - Per-slot FSM:
//      IDLE -> FALLING on allocation.
//      FALLING: on tick, y_bot <= y_bot + vel (computed 11 bits wide, no wrap).
//        If the sum >= MAX_Y, y_bot saturates to MAX_Y and the next state is DONE.
//      DONE: done_mask[i]=1 for 1 cycle -> IDLE.
//  - A slot in DONE is not allocatable in that cycle; it becomes free the cycle after.
//  - Spawn coinciding with a tick: the new slot does not move on that tick.
//  - Paint test per slot:
//      pixel_x >= x && pixel_x < x+CUBO_SIZE && pixel_y <= y_bot && pixel_y+CUBO_SIZE > y_bot.
//    The test is underflow-free near y_bot=0. The lowest index wins and the result is registered.
//  - reset_n asserted mid-fall: immediate return to IDLE; no done pulse is issued.
// CONFIGURATION
//  CUBO_COLISION_EN defined:
//    Adds inputs jug_x[9:0], jug_y[9:0] (player box, same CUBO_SIZE) and outputs colision (1 pulse) and colision_idx.
//    On a tick, a FALLING cube that overlaps the player box goes to DONE instead of moving.
//    colision and done_mask pulse in the same cycle. The lowest index is reported if several collide.
//  CUBO_COLISION_EN undefined: none of these ports exist; cubes retire only at MAX_Y.
// STRUCTURE
//  - cubo_defs.vh: slot state encodings (IDLE=0, FALLING=1, DONE=2) and default screen constants MAX_X, MAX_Y, TICK_Y.
//  - Sub-module cubo_slot: one FSM + x/y/vel registers + paint test, instantiated N_CUBOS times via generate.
//  - Top level: tick edge detector, free-slot priority encoder, paint priority mux, output registers.
// TESTING
//  - Reset: reset_n=0 mid-frame -> all outputs 0. After release: spawn_ready=1, active_mask=0.
//  - Spawn x=100 vel=2, run 5 ticks -> slot0 y_bot=10. Pixel (120,5) -> pintar_cubo=1, cubo_idx=0 one cycle later.
//  - Fill all 4 slots, spawn_valid held -> spawn_ready=0 and no 5th accept.
//    Slot1 retires -> done_mask=0010 for 1 cycle; spawn_ready=1 the following cycle; next accept lands in slot1.
//  - vel=7, y_bot=476, tick -> y_bot=480, DONE; done pulse 1 cycle later; no wrap to small y.
//  - Overlapping cubes 0 and 2 on pixel (200,50) -> cubo_idx=0. Tick condition held 3 cycles -> y advances once.
//  - CUBO_COLISION_EN: jug at (100,400), cube x=100 y_bot=420 on tick -> colision=1, colision_idx=0, slot0 IDLE after.

Source files
------------

// File: rtl/cubo_multi_caida_pkg.sv
// Shared slot-state encoding and default screen constants for the falling-cube manager.
// Optional feature macro used by the RTL: CUBO_COLISION_EN (player collision ports).
package cubo_multi_caida_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FALLING = 2'd1,
    ST_DONE    = 2'd2
  } slot_state_e;

  localparam int DEF_MAX_X  = 640;
  localparam int DEF_MAX_Y  = 480;
  localparam int DEF_TICK_Y = 481;

endpackage

// File: rtl/cubo_multi_caida_slot.sv
// One cube slot: IDLE/FALLING/DONE FSM, position and speed registers, per-pixel hit test.
// With CUBO_COLISION_EN defined, a tick that finds the cube overlapping the player retires it.
module cubo_multi_caida_slot
  import cubo_multi_caida_pkg::*;
#(
  parameter int CUBO_SIZE = 64,
  parameter int MAX_Y     = DEF_MAX_Y,
  parameter int V_W       = 3
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           alloc,
  input  logic [9:0]     alloc_x,
  input  logic [V_W-1:0] alloc_vel,
  input  logic           tick,
  input  logic [9:0]     pixel_x,
  input  logic [9:0]     pixel_y,
`ifdef CUBO_COLISION_EN
  input  logic [9:0]     jug_x,
  input  logic [9:0]     jug_y,
  output logic           col_hit,
`endif
  output slot_state_e    state,
  output logic           done,
  output logic           hit
);

  localparam logic [10:0] SIZE11 = 11'(CUBO_SIZE);
  localparam logic [10:0] LIM11  = 11'(MAX_Y);

  slot_state_e    st_q, st_d;
  logic [9:0]     x_q, x_d, y_q, y_d;
  logic [V_W-1:0] vel_q, vel_d;
  logic [10:0]    x11, y11, px11, py11, sum11;
  logic           hit_jug;

  assign x11   = {1'b0, x_q};
  assign y11   = {1'b0, y_q};
  assign px11  = {1'b0, pixel_x};
  assign py11  = {1'b0, pixel_y};
  assign sum11 = y11 + 11'(vel_q);

`ifdef CUBO_COLISION_EN
  logic [10:0] jx11, jy11;
  logic        col_q, col_d;
  assign jx11 = {1'b0, jug_x};
  assign jy11 = {1'b0, jug_y};
  // Cube rows are [y_bot-SIZE+1, y_bot], player rows [jug_y, jug_y+SIZE-1]; kept add-only.
  assign hit_jug = (x11 < jx11 + SIZE11) && (jx11 < x11 + SIZE11) &&
                   (y11 >= jy11) && (y11 + 11'd1 < jy11 + (SIZE11 << 1));
  assign col_d   = (st_q == ST_FALLING) && tick && hit_jug;
  assign col_hit = col_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) col_q <= 1'b0;
    else          col_q <= col_d;
  end
`else
  assign hit_jug = 1'b0;
`endif

  always_comb begin
    st_d  = st_q;
    x_d   = x_q;
    y_d   = y_q;
    vel_d = vel_q;
    case (st_q)
      ST_IDLE: begin
        if (alloc) begin
          st_d  = ST_FALLING;
          x_d   = alloc_x;
          y_d   = 10'd0;
          vel_d = alloc_vel;
        end
      end
      ST_FALLING: begin
        if (tick) begin
          if (hit_jug) begin
            st_d = ST_DONE;
          end else if (sum11 >= LIM11) begin
            y_d  = LIM11[9:0];
            st_d = ST_DONE;
          end else begin
            y_d = sum11[9:0];
          end
        end
      end
      ST_DONE: st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q  <= ST_IDLE;
      x_q   <= '0;
      y_q   <= '0;
      vel_q <= '0;
    end else begin
      st_q  <= st_d;
      x_q   <= x_d;
      y_q   <= y_d;
      vel_q <= vel_d;
    end
  end

  assign state = st_q;
  assign done  = (st_q == ST_DONE);
  // Comparisons rearranged so nothing is subtracted from y_bot near the top of the screen.
  assign hit   = (st_q == ST_FALLING) &&
                 (px11 >= x11) && (px11 < x11 + SIZE11) &&
                 (py11 <= y11) && (py11 + SIZE11 > y11);

endmodule

// File: rtl/cubo_multi_caida.sv
// Manager for N_CUBOS falling cubes: frame tick, slot allocation, paint priority mux.
// Define CUBO_COLISION_EN to add the player box inputs and the colision outputs.
module cubo_multi_caida
  import cubo_multi_caida_pkg::*;
#(
  parameter int N_CUBOS   = 4,
  parameter int CUBO_SIZE = 64,
  parameter int MAX_X     = DEF_MAX_X,
  parameter int MAX_Y     = DEF_MAX_Y,
  parameter int TICK_Y    = DEF_TICK_Y,
  parameter int V_W       = 3,
  localparam int IDX_W    = $clog2(N_CUBOS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [9:0]           pixel_x,
  input  logic [9:0]           pixel_y,
  input  logic                 spawn_valid,
  output logic                 spawn_ready,
  input  logic [9:0]           spawn_x,
  input  logic [V_W-1:0]       spawn_vel,
`ifdef CUBO_COLISION_EN
  input  logic [9:0]           jug_x,
  input  logic [9:0]           jug_y,
  output logic                 colision,
  output logic [IDX_W-1:0]     colision_idx,
`endif
  output logic [N_CUBOS-1:0]   active_mask,
  output logic [N_CUBOS-1:0]   done_mask,
  output logic                 pintar_cubo,
  output logic [IDX_W-1:0]     cubo_idx,
  output logic [2*N_CUBOS-1:0] dbg_state
);

  // Spawn handshake: a request transfers in the cycle spawn_valid && spawn_ready are both high;
  // spawn_ready depends only on slot state (any slot IDLE), never on spawn_valid.

  logic               tick_cond_d, tick_cond_q, tick;
  logic               pintar_d, pintar_q;
  logic [IDX_W-1:0]   idx_d, idx_q;
  logic               free_found, visible;
  logic [N_CUBOS-1:0] alloc_oh, hit_v, done_v;
  slot_state_e        st [N_CUBOS];

  assign tick_cond_d = (pixel_y == 10'(TICK_Y)) && (pixel_x == 10'd0);
  assign tick        = tick_cond_d && !tick_cond_q;

  always_comb begin
    alloc_oh   = '0;
    free_found = 1'b0;
    for (int i = 0; i < N_CUBOS; i++) begin
      if (!free_found && st[i] == ST_IDLE) begin
        alloc_oh[i] = spawn_valid;
        free_found  = 1'b1;
      end
    end
  end

  // Gated by reset_n so every output reads 0 while reset is held.
  assign spawn_ready = free_found && reset_n;

`ifdef CUBO_COLISION_EN
  logic [N_CUBOS-1:0] col_v;
  always_comb begin
    colision_idx = '0;
    for (int i = N_CUBOS - 1; i >= 0; i--) begin
      if (col_v[i]) colision_idx = IDX_W'(i);
    end
  end
  assign colision = |col_v;
`endif

  for (genvar g = 0; g < N_CUBOS; g++) begin : g_slot
    cubo_multi_caida_slot #(
      .CUBO_SIZE (CUBO_SIZE),
      .MAX_Y     (MAX_Y),
      .V_W       (V_W)
    ) u_slot (
      .clk       (clk),
      .reset_n   (reset_n),
      .alloc     (alloc_oh[g]),
      .alloc_x   (spawn_x),
      .alloc_vel (spawn_vel),
      .tick      (tick),
      .pixel_x   (pixel_x),
      .pixel_y   (pixel_y),
`ifdef CUBO_COLISION_EN
      .jug_x     (jug_x),
      .jug_y     (jug_y),
      .col_hit   (col_v[g]),
`endif
      .state     (st[g]),
      .done      (done_v[g]),
      .hit       (hit_v[g])
    );
    assign active_mask[g]       = (st[g] == ST_FALLING);
    assign dbg_state[2*g +: 2]  = st[g];
  end

  assign done_mask = done_v;
  assign visible   = (pixel_x < 10'(MAX_X)) && (pixel_y < 10'(MAX_Y));

  always_comb begin
    pintar_d = 1'b0;
    idx_d    = '0;
    for (int i = N_CUBOS - 1; i >= 0; i--) begin
      if (hit_v[i]) begin
        pintar_d = 1'b1;
        idx_d    = IDX_W'(i);
      end
    end
    if (!visible) begin
      pintar_d = 1'b0;
      idx_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cond_q <= 1'b0;
      pintar_q    <= 1'b0;
      idx_q       <= '0;
    end else begin
      tick_cond_q <= tick_cond_d;
      pintar_q    <= pintar_d;
      idx_q       <= idx_d;
    end
  end

  assign pintar_cubo = pintar_q;
  assign cubo_idx    = idx_q;

endmodule

// File: tb/tb_cubo_multi_caida.sv
// Directed bench for cubo_multi_caida: reset, spawn/fill, fall, retire, paint priority, held tick.
// Builds with or without CUBO_COLISION_EN; collision ports are tied off when present.
module tb_cubo_multi_caida;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] pixel_x, pixel_y, spawn_x;
  logic       spawn_valid, spawn_ready;
  logic [2:0] spawn_vel;
  logic [3:0] active_mask, done_mask;
  logic       pintar_cubo;
  logic [1:0] cubo_idx;
  logic [7:0] dbg_state;
  int         total = 0;
  int         bad   = 0;

`ifdef CUBO_COLISION_EN
  logic [9:0] jug_x = 10'd1000;
  logic [9:0] jug_y = 10'd1000;
  logic       colision;
  logic [1:0] colision_idx;
`endif

  cubo_multi_caida dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .spawn_valid  (spawn_valid),
    .spawn_ready  (spawn_ready),
    .spawn_x      (spawn_x),
    .spawn_vel    (spawn_vel),
`ifdef CUBO_COLISION_EN
    .jug_x        (jug_x),
    .jug_y        (jug_y),
    .colision     (colision),
    .colision_idx (colision_idx),
`endif
    .active_mask  (active_mask),
    .done_mask    (done_mask),
    .pintar_cubo  (pintar_cubo),
    .cubo_idx     (cubo_idx),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Off-screen parking spot: never a tick, never painted.
  task automatic park();
    pixel_x = 10'd700;
    pixel_y = 10'd500;
  endtask

  task automatic tick_once();
    pixel_x = 10'd0;
    pixel_y = 10'd481;
    @(negedge clk);
    park();
    @(negedge clk);
  endtask

  task automatic probe(input int x, input int y, input logic ep, input logic [1:0] ei,
                       input string tag);
    pixel_x = 10'(x);
    pixel_y = 10'(y);
    @(negedge clk);
    check({tag, "_pintar"}, pintar_cubo, ep);
    check({tag, "_idx"}, cubo_idx, ei);
    park();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n     = 1'b0;
    spawn_valid = 1'b0;
    spawn_x     = 10'd0;
    spawn_vel   = 3'd0;
    pixel_x     = 10'd120;
    pixel_y     = 10'd200;
    repeat (2) @(negedge clk);
    check("rst_ready",  spawn_ready, 0);
    check("rst_active", active_mask, 0);
    check("rst_done",   done_mask,   0);
    check("rst_pintar", pintar_cubo, 0);
    check("rst_idx",    cubo_idx,    0);
    check("rst_state",  dbg_state,   0);

    reset_n = 1'b1;
    park();
    #1;
    check("rel_ready",  spawn_ready, 1);
    check("rel_active", active_mask, 0);
    @(negedge clk);

    // Slot 0: x=100 vel=2, five ticks -> y_bot=10.
    spawn_valid = 1'b1;
    spawn_x     = 10'd100;
    spawn_vel   = 3'd2;
    @(negedge clk);
    spawn_valid = 1'b0;
    check("sp0_active", active_mask, 4'b0001);
    check("sp0_state",  dbg_state[1:0], 2'd1);
    repeat (5) tick_once();
    probe(120, 5,  1'b1, 2'd0, "p_120_5");
    probe(120, 10, 1'b1, 2'd0, "p_ybot");
    probe(120, 11, 1'b0, 2'd0, "p_below");
    probe(99,  5,  1'b0, 2'd0, "p_left");
    probe(163, 0,  1'b1, 2'd0, "p_top_row");
    probe(164, 5,  1'b0, 2'd0, "p_right");

    // Fill slots 1..3 back to back, then hold a fifth request.
    spawn_valid = 1'b1;
    spawn_x = 10'd300; spawn_vel = 3'd7;
    @(negedge clk);
    spawn_x = 10'd150; spawn_vel = 3'd2;
    @(negedge clk);
    spawn_x = 10'd500; spawn_vel = 3'd0;
    @(negedge clk);
    spawn_x = 10'd400; spawn_vel = 3'd1;
    #1;
    check("full_ready",  spawn_ready, 0);
    check("full_active", active_mask, 4'b1111);

    // 67 single ticks then one tick condition held 3 cycles: 68 advances in total.
    repeat (67) tick_once();
    pixel_x = 10'd0;
    pixel_y = 10'd481;
    repeat (3) @(negedge clk);
    park();
    @(negedge clk);
    check("held_active", active_mask, 4'b1111);
    check("held_done",   done_mask,   0);
    check("held_ready",  spawn_ready, 0);

    // y_bot now: s0=146, s1=476, s2=136, s3=0.
    probe(300, 476, 1'b1, 2'd1, "p_s1_476");
    probe(300, 477, 1'b0, 2'd0, "p_s1_477");
    probe(155, 100, 1'b1, 2'd0, "p_ovl_0_2");
    probe(200, 100, 1'b1, 2'd2, "p_s2_only");
    probe(155, 140, 1'b1, 2'd0, "p_s0_only");
    probe(155, 146, 1'b1, 2'd0, "p_s0_ybot");
    probe(155, 147, 1'b0, 2'd0, "p_held_once");
    probe(155, 75,  1'b1, 2'd2, "p_s2_top");
    probe(510, 0,   1'b1, 2'd3, "p_vel0");
    probe(510, 1,   1'b0, 2'd0, "p_vel0_below");

    // Slot 1: 476+7 saturates to 480 and retires.
    pixel_x = 10'd0;
    pixel_y = 10'd481;
    @(negedge clk);
    park();
    #1;
    check("ret_done",   done_mask,   4'b0010);
    check("ret_active", active_mask, 4'b1101);
    check("ret_ready",  spawn_ready, 0);
    check("ret_state",  dbg_state[3:2], 2'd2);
    @(negedge clk);
    check("free_done",   done_mask,   0);
    check("free_ready",  spawn_ready, 1);
    check("free_active", active_mask, 4'b1101);
    @(negedge clk);
    spawn_valid = 1'b0;
    check("re_active", active_mask, 4'b1111);
    check("re_state",  dbg_state[3:2], 2'd1);
    probe(400, 0, 1'b1, 2'd1, "p_respawn");

    // Reset in mid-fall: everything clears, no done pulse afterwards.
    reset_n = 1'b0;
    #1;
    check("mid_active", active_mask, 0);
    check("mid_done",   done_mask,   0);
    check("mid_ready",  spawn_ready, 0);
    check("mid_state",  dbg_state,   0);
    check("mid_pintar", pintar_cubo, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_done",   done_mask,   0);
    check("post_active", active_mask, 0);
    check("post_ready",  spawn_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
